// File: rtl/ras_call_return_ctrl.sv
// Return-stack front-end controller: classifies fetched instructions into RSB push/pop
// requests, queues return predictions in order and scores them against resolved targets.
module ras_call_return_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,

    input  logic                         fetch_valid_i,
    output logic                         fetch_ready_o,
    input  logic [31:0]                  fetch_instr_i,
    input  logic [ADDR_WIDTH-1:0]        fetch_pc_i,

    output logic                         rsb_push_en_o,
    output logic [ADDR_WIDTH-1:0]        rsb_push_addr_o,
    output logic                         rsb_pop_en_o,
    input  logic [ADDR_WIDTH-1:0]        rsb_pop_addr_i,
    input  logic                         rsb_pop_valid_i,

    output logic                         pred_valid_o,
    output logic [ADDR_WIDTH-1:0]        pred_target_o,

    input  logic                         resolve_valid_i,
    input  logic [ADDR_WIDTH-1:0]        resolve_target_i,
    input  logic                         flush_i,

    output logic                         mispredict_o,
    output logic [ADDR_WIDTH-1:0]        mispredict_target_o,
    output logic [$clog2(FIFO_DEPTH):0]  outstanding_o,
    output logic [COUNT_WIDTH-1:0]       hit_count_o,
    output logic [COUNT_WIDTH-1:0]       miss_count_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [6:0]             OP_JAL     = 7'b1101111;
    localparam logic [6:0]             OP_JALR    = 7'b1100111;
    localparam logic [PTR_W:0]         FULL_COUNT = FIFO_DEPTH[PTR_W:0];
    localparam logic [PTR_W:0]         COUNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0]       PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH-1:0] STAT_ONE   = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0]  INSTR_SIZE = ADDR_WIDTH'(4);

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic        is_jal;
    logic        is_jalr;
    logic        rd_link;
    logic        rs1_link;
    logic        is_push;
    logic        is_pop;
    logic        unused_instr_bits;

    logic        accept;
    logic        enq;
    logic        deq;
    logic        hit;
    logic        miss;

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;
    logic [FIFO_DEPTH-1:0] fifo_valid;
    logic [ADDR_WIDTH-1:0] fifo_target [FIFO_DEPTH];

    logic                  pred_valid;
    logic [ADDR_WIDTH-1:0] pred_target;
    logic                  mispredict;
    logic [ADDR_WIDTH-1:0] mispredict_target;
    logic [COUNT_WIDTH-1:0] hit_count;
    logic [COUNT_WIDTH-1:0] miss_count;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    assign opcode   = fetch_instr_i[6:0];
    assign rd       = fetch_instr_i[11:7];
    assign funct3   = fetch_instr_i[14:12];
    assign rs1      = fetch_instr_i[19:15];
    assign unused_instr_bits = ^fetch_instr_i[31:20];

    assign is_jal   = (opcode == OP_JAL);
    assign is_jalr  = (opcode == OP_JALR) && (funct3 == 3'b000);
    assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
    assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);

    // A linking JALR always pushes; it also pops unless it re-links through the
    // same register (rd == rs1), which is a plain call rather than a coroutine swap.
    always_comb begin
        is_push = 1'b0;
        is_pop  = 1'b0;
        if (is_jal) begin
            is_push = rd_link;
        end else if (is_jalr) begin
            is_push = rd_link;
            is_pop  = rs1_link && (!rd_link || (rd != rs1));
        end
    end

    // ------------------------------------------------------------------
    // Handshake and RSB requests
    // ------------------------------------------------------------------
    assign fetch_ready_o   = (count != FULL_COUNT);
    assign accept          = fetch_valid_i && fetch_ready_o && !flush_i;

    assign rsb_push_en_o   = accept && is_push;
    assign rsb_pop_en_o    = accept && is_pop;
    assign rsb_push_addr_o = fetch_pc_i + INSTR_SIZE;

    assign enq  = rsb_pop_en_o;
    assign deq  = resolve_valid_i && !flush_i && (count != '0);
    assign hit  = deq && fifo_valid[rd_ptr] && (fifo_target[rd_ptr] == resolve_target_i);
    assign miss = deq && !hit;

    // ------------------------------------------------------------------
    // Outstanding-return FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (enq) begin
            fifo_valid[wr_ptr]  <= rsb_pop_valid_i;
            fifo_target[wr_ptr] <= rsb_pop_addr_i;
        end
    end

    // Depth is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (enq && !deq) begin
                count <= count + COUNT_ONE;
            end else if (!enq && deq) begin
                count <= count - COUNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Prediction and misprediction outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pred_valid        <= 1'b0;
            pred_target       <= '0;
            mispredict        <= 1'b0;
            mispredict_target <= '0;
        end else begin
            pred_valid <= enq && rsb_pop_valid_i;
            if (enq) begin
                pred_target <= rsb_pop_addr_i;
            end
            mispredict <= miss;
            if (miss) begin
                mispredict_target <= resolve_target_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating hit/miss statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit && (hit_count != '1)) begin
                hit_count <= hit_count + STAT_ONE;
            end
            if (miss && (miss_count != '1)) begin
                miss_count <= miss_count + STAT_ONE;
            end
        end
    end

    assign pred_valid_o        = pred_valid;
    assign pred_target_o       = pred_target;
    assign mispredict_o        = mispredict;
    assign mispredict_target_o = mispredict_target;
    assign outstanding_o       = count;
    assign hit_count_o         = hit_count;
    assign miss_count_o        = miss_count;

endmodule

// File: tb/tb_ras_call_return_ctrl.sv
// Bench for ras_call_return_ctrl: directed scenarios followed by random traffic, all
// scored against a queue-based model of the return-prediction bookkeeping.
module tb_ras_call_return_ctrl;

    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    localparam logic [31:0] JAL_X1 = 32'h000000EF;
    localparam logic [31:0] RET    = 32'h00008067;
    localparam logic [31:0] CORO   = 32'h000280E7;
    localparam logic [31:0] NOP    = 32'h00000013;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_valid;
    logic          fetch_ready;
    logic [31:0]   fetch_instr;
    logic [AW-1:0] fetch_pc;
    logic          push_en;
    logic [AW-1:0] push_addr;
    logic          pop_en;
    logic [AW-1:0] pop_addr;
    logic          pop_valid;
    logic          pred_valid;
    logic [AW-1:0] pred_target;
    logic          resolve_valid;
    logic [AW-1:0] resolve_target;
    logic          flush;
    logic          mispredict;
    logic [AW-1:0] mispredict_target;
    logic [$clog2(DEPTH):0] outstanding;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model state: each queue entry is {prediction valid, predicted target}.
    logic [AW:0]   mq[$];
    bit            m_pv;
    logic [AW-1:0] m_pt;
    bit            m_mp;
    logic [AW-1:0] m_mt;
    int            m_hit;
    int            m_miss;

    ras_call_return_ctrl #(
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (DEPTH),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .fetch_valid_i      (fetch_valid),
        .fetch_ready_o      (fetch_ready),
        .fetch_instr_i      (fetch_instr),
        .fetch_pc_i         (fetch_pc),
        .rsb_push_en_o      (push_en),
        .rsb_push_addr_o    (push_addr),
        .rsb_pop_en_o       (pop_en),
        .rsb_pop_addr_i     (pop_addr),
        .rsb_pop_valid_i    (pop_valid),
        .pred_valid_o       (pred_valid),
        .pred_target_o      (pred_target),
        .resolve_valid_i    (resolve_valid),
        .resolve_target_i   (resolve_target),
        .flush_i            (flush),
        .mispredict_o       (mispredict),
        .mispredict_target_o(mispredict_target),
        .outstanding_o      (outstanding),
        .hit_count_o        (hit_count),
        .miss_count_o       (miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Returns {push, pop}, following the call/return/coroutine rules case by case.
    function automatic logic [1:0] classify(input logic [31:0] ins);
        logic [4:0] rd_f  = ins[11:7];
        logic [4:0] rs1_f = ins[19:15];
        bit rd_l  = (rd_f == 5'd1) || (rd_f == 5'd5);
        bit rs1_l = (rs1_f == 5'd1) || (rs1_f == 5'd5);
        if (ins[6:0] == 7'b1101111) return rd_l ? 2'b10 : 2'b00;
        if (ins[6:0] == 7'b1100111 && ins[14:12] == 3'b000) begin
            if (rd_l && !rs1_l)                 return 2'b10;
            if (rd_l && rs1_l && rs1_f == rd_f) return 2'b10;
            if (!rd_l && rs1_l)                 return 2'b01;
            if (rd_l && rs1_l)                  return 2'b11;
        end
        return 2'b00;
    endfunction

    function automatic logic [4:0] rand_reg();
        case ($urandom_range(0, 4))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd5;
            3: return 5'd2;
            default: return 5'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        logic [6:0]  op;
        logic [2:0]  f3;
        case ($urandom_range(0, 3))
            0:       op = 7'b1101111;
            1, 2:    op = 7'b1100111;
            default: op = 7'($urandom);
        endcase
        f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
        return {r[31:20], rand_reg(), f3, rand_reg(), op};
    endfunction

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic tick();
        bit            ready;
        bit            acc;
        bit            mpush;
        bit            mpop;
        bit            deq;
        bit            hit;
        logic [1:0]    cls;
        logic [AW:0]   head;
        logic [AW-1:0] exp_pa;
        #1;
        ready  = (mq.size() != DEPTH);
        acc    = fetch_valid && ready && !flush;
        cls    = classify(fetch_instr);
        mpush  = acc && cls[1];
        mpop   = acc && cls[0];
        exp_pa = fetch_pc + 32'd4;
        check("fetch_ready", fetch_ready, ready);
        check("push_en", push_en, mpush);
        check("pop_en", pop_en, mpop);
        check("push_addr", push_addr, exp_pa);

        if (rst) begin
            mq.delete();
            m_pv = 0; m_pt = '0; m_mp = 0; m_mt = '0; m_hit = 0; m_miss = 0;
        end else begin
            deq  = resolve_valid && !flush && (mq.size() != 0);
            m_pv = mpop && pop_valid;
            if (mpop) m_pt = pop_addr;
            m_mp = 0;
            if (deq) begin
                head = mq.pop_front();
                hit  = head[AW] && (head[AW-1:0] == resolve_target);
                if (hit) begin
                    if (m_hit < CMAX) m_hit++;
                end else begin
                    if (m_miss < CMAX) m_miss++;
                    m_mp = 1;
                    m_mt = resolve_target;
                end
            end
            if (mpop) mq.push_back({pop_valid, pop_addr});
            if (flush) mq.delete();
        end

        @(posedge clk);
        #1;
        check("pred_valid", pred_valid, m_pv);
        check("pred_target", pred_target, m_pt);
        check("mispredict", mispredict, m_mp);
        check("mispredict_target", mispredict_target, m_mt);
        check("outstanding", outstanding, mq.size());
        check("hit_count", hit_count, m_hit);
        check("miss_count", miss_count, m_miss);
    endtask

    task automatic drive(input bit fv, input logic [31:0] ins, input logic [AW-1:0] pc,
                         input bit pv, input logic [AW-1:0] pa,
                         input bit rv, input logic [AW-1:0] rt, input bit fl);
        fetch_valid    = fv;
        fetch_instr    = ins;
        fetch_pc       = pc;
        pop_valid      = pv;
        pop_addr       = pa;
        resolve_valid  = rv;
        resolve_target = rt;
        flush          = fl;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        fetch_valid = 0; fetch_instr = NOP; fetch_pc = '0;
        pop_valid = 0; pop_addr = '0; resolve_valid = 0; resolve_target = '0; flush = 0;
        repeat (2) @(posedge clk);
        #1;
        tick();
        rst = 1'b0;

        // Call, then a predicted return resolved correctly.
        drive(1, JAL_X1, 32'h100, 0, 32'h0,   0, 32'h0,   0);
        drive(1, RET,    32'h200, 1, 32'h104, 0, 32'h0,   0);
        drive(0, NOP,    32'h0,   0, 32'h0,   1, 32'h104, 0);
        drive(0, NOP,    32'h0,   0, 32'h0,   0, 32'h0,   0);

        // Wrong target, then a return with no RSB prediction.
        drive(1, RET,    32'h200, 1, 32'h104, 0, 32'h0,   0);
        drive(0, NOP,    32'h0,   0, 32'h0,   1, 32'h300, 0);
        drive(0, NOP,    32'h0,   0, 32'h0,   0, 32'h0,   0);
        drive(1, RET,    32'h210, 0, 32'h555, 0, 32'h0,   0);
        drive(0, NOP,    32'h0,   0, 32'h0,   1, 32'h777, 0);
        drive(0, NOP,    32'h0,   0, 32'h0,   1, 32'h777, 0);

        // Coroutine swap pushes and pops together.
        drive(1, CORO,   32'h400, 1, 32'h900, 0, 32'h0,   0);
        drive(0, NOP,    32'h0,   0, 32'h0,   1, 32'h900, 0);

        // Fill the queue, stall, drain one, then enqueue and dequeue together.
        for (int i = 0; i < DEPTH; i++)
            drive(1, RET, 32'h500 + 32'(4 * i), 1, 32'h600 + 32'(4 * i), 0, 32'h0, 0);
        drive(1, RET,    32'h520, 1, 32'h700, 0, 32'h0,   0);
        drive(0, NOP,    32'h0,   0, 32'h0,   1, 32'h600, 0);
        drive(1, RET,    32'h530, 1, 32'h710, 1, 32'h604, 0);

        // Flush with three outstanding, a call and a resolve all in one cycle.
        drive(1, JAL_X1, 32'h100, 0, 32'h0,   1, 32'h608, 1);
        drive(0, NOP,    32'h0,   0, 32'h0,   1, 32'h608, 0);

        // Push both statistics counters into saturation.
        for (int i = 0; i < CMAX + 3; i++) begin
            drive(1, RET, 32'h800, 1, 32'hA00 + 32'(i), 0, 32'h0, 0);
            drive(0, NOP, 32'h0,   0, 32'h0, 1, 32'hA00 + 32'(i), 0);
            drive(1, RET, 32'h804, 1, 32'hB00, 0, 32'h0, 0);
            drive(0, NOP, 32'h0,   0, 32'h0, 1, 32'hC00 + 32'(i), 0);
        end

        // PC at the top of the address space wraps the return address.
        drive(1, JAL_X1, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0);

        // Reset mid-stream with entries and a mispredict pending.
        drive(1, RET,    32'h900, 1, 32'h123, 0, 32'h0,   0);
        drive(1, RET,    32'h904, 1, 32'h456, 1, 32'h999, 0);
        rst = 1'b1;
        drive(0, NOP,    32'h0,   0, 32'h0,   1, 32'h456, 0);
        rst = 1'b0;
        drive(0, NOP,    32'h0,   0, 32'h0,   1, 32'h456, 0);

        // Random traffic.
        for (int i = 0; i < 1200; i++) begin
            rst            = ($urandom_range(0, 79) == 0);
            fetch_valid    = rst ? 1'b0 : ($urandom_range(0, 3) != 0);
            fetch_instr    = rand_instr();
            fetch_pc       = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            pop_valid      = ($urandom_range(0, 4) != 0);
            pop_addr       = ($urandom_range(0, 3) == 0) ? 32'($urandom)
                                                         : 32'h1000 + 32'(4 * $urandom_range(0, 7));
            resolve_valid  = ($urandom_range(0, 2) == 0);
            if (mq.size() != 0 && $urandom_range(0, 1) == 1)
                resolve_target = mq[0][AW-1:0];
            else
                resolve_target = 32'h1000 + 32'(4 * $urandom_range(0, 7));
            flush          = ($urandom_range(0, 24) == 0);
            tick();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
